// File: rtl/chksum_pkg.sv
// Shared types and helpers for the RFC 1071 checksum engine: FSM state encoding,
// accumulator width, the end-around fold and the legal parameter ranges.
package chksum_pkg;

  localparam int ACC_W         = 32;
  localparam int DATA_W_NARROW = 8;
  localparam int DATA_W_WIDE   = 16;
  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_FOLD1 = 3'd3,
    S_FOLD2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // One end-around step: low half plus carries from the high half.
  function automatic logic [ACC_W-1:0] fold(input logic [ACC_W-1:0] acc);
    return {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};
  endfunction

endpackage

// File: rtl/chksum_rd_pipe.sv
// Tags RAM reads across the RD_LAT read latency and packs returning data into
// big-endian 16-bit words (byte pairing for 8-bit ports, lane masking for 16-bit).
module chksum_rd_pipe
  import chksum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_en,
  input  logic              rd_last,
  input  logic              odd_len,
  input  logic [DATA_W-1:0] rd_data,
  output logic              word_vld,
  output logic [15:0]       word
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] last_q;
  logic              tag_vld;
  logic              tag_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (clear) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= RD_LAT'({vld_q, rd_en});
      last_q <= RD_LAT'({last_q, rd_en & rd_last});
    end
  end

  assign tag_vld  = vld_q[RD_LAT-1];
  assign tag_last = last_q[RD_LAT-1];

  generate
    if (DATA_W == DATA_W_WIDE) begin : g_wide
      assign word_vld = tag_vld;
      assign word     = (tag_last && odd_len) ? {rd_data[15:8], 8'h00} : rd_data[15:0];
    end else begin : g_narrow
      // parity=0 expects the high byte of a word; an odd final byte is padded low.
      logic       parity;
      logic [7:0] hi_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          parity <= 1'b0;
          hi_q   <= 8'h00;
        end else if (clear) begin
          parity <= 1'b0;
        end else if (tag_vld) begin
          parity <= ~parity;
          if (!parity) hi_q <= rd_data;
        end
      end

      assign word_vld = tag_vld && (parity || (tag_last && odd_len));
      assign word     = parity ? {hi_q, rd_data} : {rd_data, 8'h00};
    end
  endgenerate

endmodule

// File: rtl/chksum_engine.sv
// RFC 1071 checksum over a region of the transmit RAM, one read per cycle.
// Optional oVerifyOk output is built when CHKSUM_VERIFY_EN is defined.
module chksum_engine
  import chksum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              iDm9000aClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [LEN_W-1:0]  iLen,
  input  logic [ADDR_W-1:0] iStartAddr,
  input  logic [15:0]       iSeed,
  input  logic              iInvert,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [DATA_W-1:0] iRdData,
  output logic [15:0]       oChecksum,
  output logic              oBusy,
  output logic              oDone,
`ifdef CHKSUM_VERIFY_EN
  output logic              oVerifyOk,
`endif
  output logic [2:0]        dbg_state
);

  generate
    if ((DATA_W != DATA_W_NARROW && DATA_W != DATA_W_WIDE) ||
        RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_param
      $error("chksum_engine: illegal DATA_W or RD_LAT");
    end
  endgenerate

  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  state_t           state;
  logic [LEN_W-1:0] rd_left;
  logic [1:0]       drain_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] folded;
  logic             invert_q;
  logic             odd_q;
  logic [LEN_W:0]   len_ext;
  logic [LEN_W-1:0] n_reads;
  logic             rd_last;
  logic             word_vld;
  logic [15:0]      word;

  assign len_ext = {1'b0, iLen};
  assign n_reads = (DATA_W == DATA_W_WIDE) ? LEN_W'((len_ext + (LEN_W+1)'(1)) >> 1) : iLen;
  assign rd_last = (rd_left == LEN_W'(1));
  assign folded  = fold(acc);
  assign dbg_state = state;

  chksum_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (iDm9000aClk),
    .rst      (iReset),
    .clear    (state == S_IDLE && iStart),
    .rd_en    (oRdEn),
    .rd_last  (rd_last),
    .odd_len  (odd_q),
    .rd_data  (iRdData),
    .word_vld (word_vld),
    .word     (word)
  );

  always_ff @(posedge iDm9000aClk or posedge iReset) begin
    if (iReset) begin
      state     <= S_IDLE;
      oRdEn     <= 1'b0;
      oRdAddr   <= '0;
      rd_left   <= '0;
      drain_cnt <= 2'd0;
      acc       <= '0;
      invert_q  <= 1'b0;
      odd_q     <= 1'b0;
      oChecksum <= 16'h0000;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
`ifdef CHKSUM_VERIFY_EN
      oVerifyOk <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      if (word_vld) acc <= acc + {16'h0000, word};
      case (state)
        S_IDLE: begin
          if (iStart) begin
            acc       <= {16'h0000, iSeed};
            invert_q  <= iInvert;
            odd_q     <= iLen[0];
            oBusy     <= 1'b1;
            oRdAddr   <= iStartAddr;
            rd_left   <= n_reads;
            drain_cnt <= DRAIN_INIT;
            if (n_reads == '0) begin
              state <= S_DRAIN;
            end else begin
              oRdEn <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          oRdAddr <= oRdAddr + ADDR_W'(1);
          rd_left <= rd_left - LEN_W'(1);
          if (rd_last) begin
            oRdEn <= 1'b0;
            state <= S_DRAIN;
          end
        end
        // Last read's data lands in the final DRAIN cycle, so RD_LAT cycles suffice.
        S_DRAIN: begin
          if (drain_cnt == 2'd0) state <= S_FOLD1;
          else drain_cnt <= drain_cnt - 2'd1;
        end
        S_FOLD1: begin
          acc   <= folded;
          state <= S_FOLD2;
        end
        S_FOLD2: begin
          acc       <= folded;
          oChecksum <= invert_q ? ~folded[15:0] : folded[15:0];
`ifdef CHKSUM_VERIFY_EN
          oVerifyOk <= (folded[15:0] == 16'hFFFF);
`endif
          oDone     <= 1'b1;
          oBusy     <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/chksum_engine.md
Name: chksum_engine

Overview:
Parametrised RFC 1071 Internet checksum engine, the successor to the single-byte, multi-cycle-per-byte checksum FSM in the DM9000A Ethernet transmit path.
Reads a frame region from the transmit dual-port RAM with one read issued per cycle, pipelined over a configurable RAM read latency. Supports 8- or 16-bit RAM ports, odd lengths, a pseudo-header seed, and optional output inversion.
Used by the IP/UDP header builder before frame transfer to the DM9000A.

Parameters:
DATA_W, 8, RAM read-port width; legal values 8 or 16.
ADDR_W, 10, RAM address width.
LEN_W, 16, byte-length width.
RD_LAT, 1, RAM read latency in cycles from oRdEn to valid iRdData; legal range 1..3.

Ports:
iDm9000aClk  in  1  system clock.
iReset  in  1  asynchronous active-high reset.
iStart  in  1  single-cycle start pulse; ignored while oBusy=1.
iLen  in  LEN_W  byte count to sum; sampled on iStart.
iStartAddr  in  ADDR_W  first RAM word address; sampled on iStart.
iSeed  in  16  initial partial sum (pseudo-header); sampled on iStart.
iInvert  in  1  1 = output ones-complement of the folded sum; sampled on iStart.
oRdEn  out  1  RAM read enable.
oRdAddr  out  ADDR_W  RAM read address.
iRdData  in  DATA_W  RAM read data.
oChecksum  out  16  result; held until the next iStart.
oBusy  out  1  high from the cycle after iStart until oDone.
oDone  out  1  one-cycle completion pulse.

Behaviour:
Reset: asynchronous, active-high. All state returns to IDLE; oRdEn, oRdAddr, oChecksum, oBusy and oDone are all 0.
Reset mid-operation: abort immediately; no oDone is produced. The in-flight read pipeline is flushed.
States: IDLE -> FETCH -> DRAIN -> FOLD1 -> FOLD2 -> DONE -> IDLE.
IDLE: on iStart, latch the inputs, load the accumulator (32 bit) with iSeed, and set R = number of reads.
  DATA_W=8: R = len.
  DATA_W=16: R = ceil(len/2).
  If R=0, go to DRAIN directly; otherwise go to FETCH.
FETCH: oRdEn=1 for exactly R consecutive cycles. oRdAddr starts at iStartAddr and increments by 1 each cycle, wrapping modulo 2^ADDR_W. A RD_LAT-deep valid shift register tags returning data.
Byte order is big-endian: an even byte offset is the high byte of the 16-bit word.
  DATA_W=8: a byte-parity toggle pairs bytes into words before adding.
  DATA_W=16: word = iRdData[15:0], with iRdData[15:8] the first byte.
  Odd len: the final word is {last byte, 8'h00}. For DATA_W=16 the low lane of the last read is masked.
DRAIN: wait until the valid pipe is empty and any pending half-word has been added.
FOLD1: acc = acc[15:0] + acc[31:16].
FOLD2: same fold again; the result fits in 16 bits.
DONE: oChecksum = iInvert ? ~acc[15:0] : acc[15:0]; oDone=1 for one cycle; oBusy drops in the same cycle.
Latency: oDone is asserted exactly R + RD_LAT + 3 cycles after the iStart cycle. For R=0 it is RD_LAT + 3 cycles.
Overflow: a 32-bit accumulator cannot overflow for len ≤ 65535 plus the seed. No intermediate carry handling is needed.
iStart while busy: ignored; the current operation is not disturbed.
iStart in the same cycle as oDone: ignored.

Optional Feature:
CHKSUM_VERIFY_EN
Defined: adds output oVerifyOk (1 bit), valid with oDone and held until the next iStart. oVerifyOk=1 when the folded, non-inverted sum equals 16'hFFFF, i.e. the region already contains a correct checksum.
Not defined: the port and its logic are absent.

Decomposition:
Package chksum_pkg holds the state enum, ACC_W=32, the fold function (16-bit end-around add), and the legal-parameter check constants.
Sub-module chksum_rd_pipe: the RD_LAT valid shift register plus the byte/word packer. It is the natural split because it isolates the DATA_W and RD_LAT variation from the FSM.

Test Plan:
IPv4 header: 20 bytes 45 00 00 73 00 00 40 00 40 11 00 00 C0 A8 00 01 C0 A8 00 C7, seed 0, invert=1 -> oChecksum=0xB861. Run for DATA_W=8 and DATA_W=16, RD_LAT=1 and RD_LAT=3. oDone asserted at the cycle count given by the latency formula.
Odd length: bytes 01 02 03, seed 0, invert=1 -> sum 0x0402, oChecksum=0xFBFD.
Carry fold: bytes FF FF FF FF 00 01, invert=0 -> oChecksum=0x0001. Second case: len=0, seed=0x1234, invert=0 -> oChecksum=0x1234 with zero read pulses.
Address wrap: ADDR_W=10, start 0x3FF, len=4, DATA_W=8 -> oRdAddr sequence 0x3FF, 0x000, 0x001, 0x002.
Reset and busy handling:
  Assert iReset during FETCH -> all outputs 0 next edge, no oDone; a following start completes correctly.
  Pulse iStart while busy -> no effect on the result.
Verify mode (CHKSUM_VERIFY_EN defined): sum the IPv4 header with 0xB861 inserted at the checksum field -> oVerifyOk=1. Corrupt one byte -> oVerifyOk=0.
